mem_stage: RTL and testbench

- Memory-access stage of the 5-stage LoongArch pipeline, between EXE and WB.
- Accepts the EXE-to-MEM bus and selects the writeback value: load data from the data BRAM, or the ALU result.
- Captures BRAM read data in the instruction's first MEM cycle, so a WB stall never loses load data.
- Produces the MEM-to-WB bus and exports hazard/forwarding info to ID.

---
 rtl/mem_stage.sv | 115 +++++++++++
 tb/tb_mem_stage.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the 5-stage LoongArch pipeline.
// Holds one instruction between EXE and WB. It picks the writeback value,
// either BRAM load data or the ALU result. BRAM read data is captured in the
// instruction's first MEM cycle so that a WB stall cannot lose it. The stage
// also exports hazard and forwarding information to ID.
module mem_stage #(
  parameter int EXE_TO_MEM_BUS_WIDTH = 71,
  parameter int MEM_TO_WB_BUS_WIDTH  = 70
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [EXE_TO_MEM_BUS_WIDTH-1:0] exe_to_mem_bus,
  input  logic                            exe_to_mem_valid,
  output logic                            mem_allow_in,
  input  logic                            wb_allow_in,
  output logic                            mem_to_wb_valid,
  output logic [MEM_TO_WB_BUS_WIDTH-1:0]  mem_to_wb_bus,
  input  logic [31:0]                     data_sram_rdata,
  output logic                            mem_valid,
  output logic                            mem_gr_we,
  output logic [4:0]                      mem_dest,
  output logic [31:0]                     mem_fwd_data
);

  logic                            mem_valid_r;
  logic [EXE_TO_MEM_BUS_WIDTH-1:0] payload_r;
  logic                            rdata_held_r;
  logic [31:0]                     rdata_buf_r;

  logic                            mem_ready_go_s;
  logic                            accept_s;
  logic [31:0]                     alu_result_s;
  logic                            res_from_mem_s;
  logic                            gr_we_s;
  logic [4:0]                      dest_s;
  logic [31:0]                     pc_s;
  logic [31:0]                     load_data_s;
  logic [31:0]                     final_result_s;

  // Memory access is single-cycle, so the stage is always ready to leave.
  assign mem_ready_go_s  = 1'b1;
  assign mem_to_wb_valid = mem_valid_r & mem_ready_go_s;
  assign mem_allow_in    = ~mem_valid_r | (mem_ready_go_s & wb_allow_in);
  assign accept_s        = exe_to_mem_valid & mem_allow_in;
  assign mem_valid       = mem_valid_r;

  // Unpack the held payload: {alu_result, res_from_mem, gr_we, dest, pc}.
  assign alu_result_s   = payload_r[70:39];
  assign res_from_mem_s = payload_r[38];
  assign gr_we_s        = payload_r[37];
  assign dest_s         = payload_r[36:32];
  assign pc_s           = payload_r[31:0];

  // Stage valid bit: it advances whenever the stage can take a new slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_valid_r <= 1'b0;
    end else if (mem_allow_in) begin
      mem_valid_r <= exe_to_mem_valid;
    end else begin
      mem_valid_r <= mem_valid_r;
    end
  end

  // Payload register: it loads only on a real acceptance and holds through bubbles.
  always_ff @(posedge clk) begin
    if (reset) begin
      payload_r <= {EXE_TO_MEM_BUS_WIDTH{1'b0}};
    end else if (accept_s) begin
      payload_r <= exe_to_mem_bus;
    end else begin
      payload_r <= payload_r;
    end
  end

  // First-cycle capture of BRAM read data. Later BRAM output belongs to the
  // next EXE request and must not leak into an instruction stalled here.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_held_r <= 1'b0;
      rdata_buf_r  <= 32'h0000_0000;
    end else if (accept_s) begin
      rdata_held_r <= 1'b0;
      rdata_buf_r  <= rdata_buf_r;
    end else if (mem_valid_r && !rdata_held_r) begin
      rdata_held_r <= 1'b1;
      rdata_buf_r  <= data_sram_rdata;
    end else begin
      rdata_held_r <= rdata_held_r;
      rdata_buf_r  <= rdata_buf_r;
    end
  end

  // Writeback value select: the captured load data once held, the live BRAM data before that.
  always_comb begin
    load_data_s    = data_sram_rdata;
    final_result_s = alu_result_s;
    if (rdata_held_r) begin
      load_data_s = rdata_buf_r;
    end else begin
      load_data_s = data_sram_rdata;
    end
    if (res_from_mem_s) begin
      final_result_s = load_data_s;
    end else begin
      final_result_s = alu_result_s;
    end
  end

  assign mem_to_wb_bus = {final_result_s, gr_we_s, dest_s, pc_s};
  assign mem_fwd_data  = final_result_s;
  assign mem_gr_we     = gr_we_s;
  assign mem_dest      = dest_s;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: table-driven vectors plus hand-written multi-cycle sequences.
// A scoreboard queue holds the expected WB payloads. Every WB handoff
// (mem_to_wb_valid & wb_allow_in) pops one entry and compares it.
module tb_mem_stage;

  logic        clk;
  logic        reset;
  logic [70:0] exe_to_mem_bus;
  logic        exe_to_mem_valid;
  logic        mem_allow_in;
  logic        wb_allow_in;
  logic        mem_to_wb_valid;
  logic [69:0] mem_to_wb_bus;
  logic [31:0] data_sram_rdata;
  logic        mem_valid;
  logic        mem_gr_we;
  logic [4:0]  mem_dest;
  logic [31:0] mem_fwd_data;

  int n_cmp = 0;
  int n_err = 0;
  logic [69:0] sb_q[$];

  mem_stage #(
    .EXE_TO_MEM_BUS_WIDTH(71),
    .MEM_TO_WB_BUS_WIDTH (70)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .exe_to_mem_bus   (exe_to_mem_bus),
    .exe_to_mem_valid (exe_to_mem_valid),
    .mem_allow_in     (mem_allow_in),
    .wb_allow_in      (wb_allow_in),
    .mem_to_wb_valid  (mem_to_wb_valid),
    .mem_to_wb_bus    (mem_to_wb_bus),
    .data_sram_rdata  (data_sram_rdata),
    .mem_valid        (mem_valid),
    .mem_gr_we        (mem_gr_we),
    .mem_dest         (mem_dest),
    .mem_fwd_data     (mem_fwd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] alu;
    logic        rfm;
    logic        we;
    logic [4:0]  dest;
    logic [31:0] pc;
    logic [31:0] rdata;
    logic [31:0] exp_result;
  } vec_t;

  function automatic logic [70:0] ebus(input logic [31:0] alu, input logic rfm,
                                       input logic we, input logic [4:0] dest,
                                       input logic [31:0] pc);
    return {alu, rfm, we, dest, pc};
  endfunction

  function automatic logic [69:0] wbus(input logic [31:0] res, input logic we,
                                       input logic [4:0] dest, input logic [31:0] pc);
    return {res, we, dest, pc};
  endfunction

  task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: each WB handoff consumes exactly one expected payload.
  always @(negedge clk) begin
    if (mem_to_wb_valid === 1'b1 && wb_allow_in === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL handoff_unexpected: got %h expected no handoff", mem_to_wb_bus);
      end else begin
        chk("handoff", mem_to_wb_bus, sb_q.pop_front());
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[6];
    vecs[0] = '{32'hA5A5A5A5, 1'b0, 1'b1, 5'd1,  32'h1C000010, 32'hFFFFFFFF, 32'hA5A5A5A5};
    vecs[1] = '{32'h00001000, 1'b1, 1'b1, 5'd2,  32'h1C000014, 32'h11111111, 32'h11111111};
    vecs[2] = '{32'h00001004, 1'b1, 1'b1, 5'd3,  32'h1C000018, 32'h22222222, 32'h22222222};
    vecs[3] = '{32'h00000000, 1'b0, 1'b0, 5'd0,  32'h1C00001C, 32'h12121212, 32'h00000000};
    vecs[4] = '{32'hFFFFFFFF, 1'b0, 1'b1, 5'd31, 32'h1C000020, 32'h00000000, 32'hFFFFFFFF};
    vecs[5] = '{32'hCAFE0000, 1'b1, 1'b1, 5'd31, 32'h1C000024, 32'h80000001, 32'h80000001};

    // ---- reset held two cycles with EXE offering ----
    reset            = 1'b1;
    exe_to_mem_valid = 1'b1;
    exe_to_mem_bus   = ebus(32'hDEAD0001, 1'b1, 1'b1, 5'd3, 32'h1C0000F0);
    wb_allow_in      = 1'b1;
    data_sram_rdata  = 32'h5A5A5A5A;
    tick();
    tick();
    chk("reset_mem_valid", 70'(mem_valid), 70'd0);
    chk("reset_wb_valid", 70'(mem_to_wb_valid), 70'd0);
    chk("reset_allow_in", 70'(mem_allow_in), 70'd1);
    chk("reset_wb_bus", mem_to_wb_bus, 70'd0);
    reset            = 1'b0;
    exe_to_mem_valid = 1'b0;
    tick();

    // ---- ALU pass-through ----
    exe_to_mem_bus   = ebus(32'h12345678, 1'b0, 1'b1, 5'd5, 32'h1C000000);
    exe_to_mem_valid = 1'b1;
    sb_q.push_back(wbus(32'h12345678, 1'b1, 5'd5, 32'h1C000000));
    tick();
    exe_to_mem_valid = 1'b0;
    #1;
    chk("alu_wb_valid", 70'(mem_to_wb_valid), 70'd1);
    chk("alu_wb_bus", mem_to_wb_bus, wbus(32'h12345678, 1'b1, 5'd5, 32'h1C000000));
    chk("alu_dest", 70'(mem_dest), 70'd5);
    chk("alu_gr_we", 70'(mem_gr_we), 70'd1);
    tick();

    // ---- table-driven back-to-back stream, WB never stalls ----
    for (int i = 0; i <= 6; i++) begin
      if (i < 6) begin
        exe_to_mem_bus   = ebus(vecs[i].alu, vecs[i].rfm, vecs[i].we, vecs[i].dest, vecs[i].pc);
        exe_to_mem_valid = 1'b1;
        sb_q.push_back(wbus(vecs[i].exp_result, vecs[i].we, vecs[i].dest, vecs[i].pc));
      end else begin
        exe_to_mem_valid = 1'b0;
      end
      if (i > 0) begin
        data_sram_rdata = vecs[i-1].rdata;
      end
      #1;
      if (i > 0) begin
        chk("vec_wb_valid", 70'(mem_to_wb_valid), 70'd1);
        chk("vec_fwd_data", 70'(mem_fwd_data), 70'(vecs[i-1].exp_result));
      end
      tick();
    end
    chk("vec_drain_valid", 70'(mem_valid), 70'd0);

    // ---- load with a three-cycle WB stall ----
    exe_to_mem_bus   = ebus(32'hAAAA0000, 1'b1, 1'b1, 5'd7, 32'h1C000100);
    exe_to_mem_valid = 1'b1;
    wb_allow_in      = 1'b1;
    sb_q.push_back(wbus(32'hDEADBEEF, 1'b1, 5'd7, 32'h1C000100));
    tick();
    exe_to_mem_bus   = ebus(32'h0000ABCD, 1'b0, 1'b1, 5'd8, 32'h1C000104);
    exe_to_mem_valid = 1'b1;
    sb_q.push_back(wbus(32'h0000ABCD, 1'b1, 5'd8, 32'h1C000104));
    wb_allow_in      = 1'b0;
    data_sram_rdata  = 32'hDEADBEEF;
    #1;
    chk("stall_allow_in_0", 70'(mem_allow_in), 70'd0);
    chk("stall_fwd_0", 70'(mem_fwd_data), 70'hDEADBEEF);
    tick();
    for (int s = 0; s < 2; s++) begin
      data_sram_rdata = 32'h0BADF00D;
      #1;
      chk("stall_allow_in", 70'(mem_allow_in), 70'd0);
      chk("stall_wb_valid", 70'(mem_to_wb_valid), 70'd1);
      chk("stall_fwd_held", 70'(mem_fwd_data), 70'hDEADBEEF);
      tick();
    end
    wb_allow_in = 1'b1;
    #1;
    chk("release_allow_in", 70'(mem_allow_in), 70'd1);
    chk("release_wb_bus", mem_to_wb_bus, wbus(32'hDEADBEEF, 1'b1, 5'd7, 32'h1C000100));
    tick();
    exe_to_mem_valid = 1'b0;
    #1;
    chk("after_stall_fwd", 70'(mem_fwd_data), 70'h0000ABCD);
    tick();

    // ---- bubble between two instructions ----
    exe_to_mem_bus   = ebus(32'h0000100A, 1'b0, 1'b1, 5'd4, 32'h00000100);
    exe_to_mem_valid = 1'b1;
    sb_q.push_back(wbus(32'h0000100A, 1'b1, 5'd4, 32'h00000100));
    tick();
    exe_to_mem_valid = 1'b0;
    #1;
    chk("bubble_a_valid", 70'(mem_to_wb_valid), 70'd1);
    tick();
    exe_to_mem_bus   = ebus(32'h0000108A, 1'b0, 1'b1, 5'd6, 32'h00000108);
    exe_to_mem_valid = 1'b1;
    sb_q.push_back(wbus(32'h0000108A, 1'b1, 5'd6, 32'h00000108));
    #1;
    chk("bubble_gap_valid", 70'(mem_to_wb_valid), 70'd0);
    chk("bubble_gap_allow", 70'(mem_allow_in), 70'd1);
    tick();
    exe_to_mem_valid = 1'b0;
    #1;
    chk("bubble_b_valid", 70'(mem_to_wb_valid), 70'd1);
    chk("bubble_b_bus", mem_to_wb_bus, wbus(32'h0000108A, 1'b1, 5'd6, 32'h00000108));
    tick();

    // ---- reset during a stalled load ----
    exe_to_mem_bus   = ebus(32'h00002000, 1'b1, 1'b1, 5'd9, 32'h00000200);
    exe_to_mem_valid = 1'b1;
    tick();
    exe_to_mem_valid = 1'b0;
    wb_allow_in      = 1'b0;
    data_sram_rdata  = 32'h33333333;
    tick();
    data_sram_rdata  = 32'h44444444;
    tick();
    reset            = 1'b1;
    exe_to_mem_valid = 1'b1;
    exe_to_mem_bus   = ebus(32'hBEEF0000, 1'b1, 1'b1, 5'd12, 32'h00000300);
    tick();
    reset            = 1'b0;
    exe_to_mem_valid = 1'b0;
    #1;
    chk("midreset_valid", 70'(mem_valid), 70'd0);
    chk("midreset_wb_valid", 70'(mem_to_wb_valid), 70'd0);
    chk("midreset_held", 70'(dut.rdata_held_r), 70'd0);
    chk("midreset_wb_bus", mem_to_wb_bus, 70'd0);
    tick();
    exe_to_mem_bus   = ebus(32'h00002004, 1'b1, 1'b1, 5'd10, 32'h00000204);
    exe_to_mem_valid = 1'b1;
    sb_q.push_back(wbus(32'h55555555, 1'b1, 5'd10, 32'h00000204));
    tick();
    exe_to_mem_valid = 1'b0;
    data_sram_rdata  = 32'h55555555;
    #1;
    chk("fresh_load_fwd", 70'(mem_fwd_data), 70'h55555555);
    tick();
    data_sram_rdata = 32'h66666666;
    #1;
    chk("fresh_load_held", 70'(mem_fwd_data), 70'h55555555);
    wb_allow_in = 1'b1;
    tick();
    tick();

    chk("scoreboard_empty", 70'(sb_q.size()), 70'd0);
    chk("final_idle", 70'(mem_valid), 70'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
